// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types for the decode-stage control logic.
//   opcode_e    : 4-bit instruction opcode (values 7..15 decode as NOP)
//   alu_op_t    : 2-bit ALU operation select, with ALU_* constants
//   ctrl_t      : control bundle handed to the DecodeExecute register
//   state_e     : hazard FSM states
//   CTRL_BUBBLE : all-zero control bundle (no write, no memory, add)
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_AND = 4'd4,
    OP_LDR = 4'd5,
    OP_STR = 4'd6
  } opcode_e;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 2'b00;
  localparam alu_op_t ALU_SUB = 2'b01;
  localparam alu_op_t ALU_MUL = 2'b10;
  localparam alu_op_t ALU_AND = 2'b11;

  typedef struct packed {
    logic    wbs;
    logic    wme;
    logic    mm;
    alu_op_t ALUop;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MUL_BUSY = 2'd2
  } state_e;

  localparam ctrl_t CTRL_BUBBLE = '{wbs: 1'b0, wme: 1'b0, mm: 1'b0, ALUop: ALU_ADD};

endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: pure combinational opcode -> control bundle.
//   opcode    in  [3:0]  instruction opcode field
//   ctrl      out ctrl_t wbs/wme/mm/ALUop for this opcode
//   reads_rs2 out        instruction sources rs2 (ADD/SUB/MUL/AND/STR)
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl,
  output logic       reads_rs2
);

  // Opcode table; unused opcodes fall through to NOP.
  always_comb begin
    ctrl      = CTRL_BUBBLE;
    reads_rs2 = 1'b0;
    case (opcode)
      OP_ADD: begin ctrl = '{1'b1, 1'b0, 1'b0, ALU_ADD}; reads_rs2 = 1'b1; end
      OP_SUB: begin ctrl = '{1'b1, 1'b0, 1'b0, ALU_SUB}; reads_rs2 = 1'b1; end
      OP_MUL: begin ctrl = '{1'b1, 1'b0, 1'b0, ALU_MUL}; reads_rs2 = 1'b1; end
      OP_AND: begin ctrl = '{1'b1, 1'b0, 1'b0, ALU_AND}; reads_rs2 = 1'b1; end
      OP_LDR: begin ctrl = '{1'b1, 1'b0, 1'b1, ALU_ADD}; end
      OP_STR: begin ctrl = '{1'b0, 1'b1, 1'b0, ALU_ADD}; reads_rs2 = 1'b1; end
      default: begin ctrl = CTRL_BUBBLE; reads_rs2 = 1'b0; end
    endcase
  end

endmodule

// File: rtl/decode_control_unit.sv
// decode_control_unit: decode-stage control generator with hazard FSM.
//   clk, rst            clock / asynchronous active-high reset
//   instr, instr_valid  IF/ID instruction and its valid flag
//   flush               squash from execute (highest priority)
//   wbs, wme, mm, ALUop control to DecodeExecute (combinational)
//   stall_f             hold PC and IF/ID this cycle
//   issue               instruction passes to DecodeExecute this cycle
// Optional (macro HAZARD_COUNTERS_EN): stall_cycles, flush_count saturating
// 16-bit event counters.
module decode_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int REG_AW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        flush,
  output logic        wbs,
  output logic        wme,
  output logic        mm,
  output logic [1:0]  ALUop,
  output logic        stall_f,
  output logic        issue
`ifdef HAZARD_COUNTERS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  state_e              state;
  logic [3:0]          cnt;
  logic                ld_pend;
  logic [REG_AW-1:0]   ld_rd;

  logic [3:0]          opcode;
  logic [REG_AW-1:0]   rd, rs1, rs2;
  ctrl_t               dec_ctrl;
  ctrl_t               out_ctrl;
  logic                reads_rs2;
  logic                hazard;
  logic                unused_imm;

  assign opcode     = instr[31:28];
  assign rd         = instr[24 +: REG_AW];
  assign rs1        = instr[20 +: REG_AW];
  assign rs2        = instr[16 +: REG_AW];
  assign unused_imm = ^instr[15:0];

  opcode_decoder u_dec (
    .opcode    (opcode),
    .ctrl      (dec_ctrl),
    .reads_rs2 (reads_rs2)
  );

  // Only RUN can detect a load-use hazard; LD_STALL already paid the bubble.
  assign hazard = (state == RUN) && instr_valid && ld_pend &&
                  ((ld_rd == rs1) || (reads_rs2 && (ld_rd == rs2)));

  // Output mux: reset and flush force a bubble without stall.
  always_comb begin
    out_ctrl = CTRL_BUBBLE;
    stall_f  = 1'b0;
    issue    = 1'b0;
    if (rst || flush) begin
      out_ctrl = CTRL_BUBBLE;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            stall_f = 1'b1;
          end else if (instr_valid) begin
            out_ctrl = dec_ctrl;
            issue    = 1'b1;
          end else begin
            out_ctrl = CTRL_BUBBLE;
          end
        end
        LD_STALL: begin
          if (instr_valid) begin
            out_ctrl = dec_ctrl;
            issue    = 1'b1;
          end else begin
            out_ctrl = CTRL_BUBBLE;
          end
        end
        MUL_BUSY: stall_f = 1'b1;
        default:  out_ctrl = CTRL_BUBBLE;
      endcase
    end
  end

  assign wbs   = out_ctrl.wbs;
  assign wme   = out_ctrl.wme;
  assign mm    = out_ctrl.mm;
  assign ALUop = out_ctrl.ALUop;

  // Hazard FSM, MUL occupancy counter and pending-load tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= 4'd0;
      ld_pend <= 1'b0;
      ld_rd   <= '0;
    end else if (flush) begin
      state   <= RUN;
      cnt     <= 4'd0;
      ld_pend <= 1'b0;
    end else begin
      case (state)
        RUN, LD_STALL: begin
          if (hazard) begin
            state <= LD_STALL;
          end else if (issue) begin
            ld_pend <= (opcode == OP_LDR);
            if (opcode == OP_LDR) ld_rd <= rd;
            // A MUL issued from either state occupies execute for MUL_LAT cycles.
            if ((opcode == OP_MUL) && (MUL_LAT > 1)) begin
              cnt   <= 4'(MUL_LAT - 1);
              state <= MUL_BUSY;
            end else begin
              state <= RUN;
            end
          end else begin
            ld_pend <= 1'b0;
            state   <= RUN;
          end
        end
        MUL_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_COUNTERS_EN
  // Saturating stall / flush event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (stall_f && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (flush && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_control_unit.sv
// Self-checking bench for decode_control_unit (MUL_LAT = 3).
module tb_decode_control_unit;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        wbs, wme, mm, stall_f, issue;
  logic [1:0]  ALUop;
`ifdef HAZARD_COUNTERS_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int failures = 0;

  decode_control_unit #(.MUL_LAT(MUL_LAT), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .flush(flush),
    .wbs(wbs), .wme(wme), .mm(mm), .ALUop(ALUop), .stall_f(stall_f), .issue(issue)
`ifdef HAZARD_COUNTERS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Model state: remaining MUL stall cycles, pending load target (-1 none),
  // and whether the current IF/ID instruction already received its bubble.
  int mul_left = 0;
  int load_rd  = -1;
  bit held     = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
    logic [3:0] o, d, a, b;
    o = op[3:0]; d = rd[3:0]; a = rs1[3:0]; b = rs2[3:0];
    return {o, d, a, b, 16'h1234};
  endfunction

  // {wbs, wme, mm, ALUop}
  function automatic logic [4:0] ctrl_of(input int op);
    case (op)
      1: return 5'b100_00;
      2: return 5'b100_01;
      3: return 5'b100_10;
      4: return 5'b100_11;
      5: return 5'b101_00;
      6: return 5'b010_00;
      default: return 5'b000_00;
    endcase
  endfunction

  function automatic bit m_hazard();
    int op, r1, r2;
    bit uses2;
    op = int'(instr[31:28]);
    r1 = int'(instr[23:20]);
    r2 = int'(instr[19:16]);
    uses2 = (op >= 1 && op <= 4) || op == 6;
    return instr_valid && (load_rd >= 0) && !held && (r1 == load_rd || (uses2 && r2 == load_rd));
  endfunction

  // {wbs, wme, mm, ALUop, stall_f, issue}
  function automatic logic [6:0] m_expect();
    if (rst || flush) return 7'b0000000;
    if (mul_left > 0) return 7'b0000010;
    if (m_hazard()) return 7'b0000010;
    if (instr_valid) return {ctrl_of(int'(instr[31:28])), 2'b01};
    return 7'b0000000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_left <= 0; load_rd <= -1; held <= 1'b0; m_stall <= 0; m_flush <= 0;
    end else begin
      if (m_expect() & 7'b0000010) m_stall <= (m_stall < 65535) ? m_stall + 1 : m_stall;
      if (flush) m_flush <= (m_flush < 65535) ? m_flush + 1 : m_flush;
      if (flush) begin
        mul_left <= 0; load_rd <= -1; held <= 1'b0;
      end else if (mul_left > 0) begin
        mul_left <= mul_left - 1;
      end else if (m_hazard()) begin
        held <= 1'b1;
      end else if (instr_valid) begin
        held <= 1'b0;
        load_rd <= (instr[31:28] == 4'd5) ? int'(instr[27:24]) : -1;
        if (instr[31:28] == 4'd3) mul_left <= MUL_LAT - 1;
      end else begin
        held <= 1'b0; load_rd <= -1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [6:0] exp_v, act_v;
    exp_v = m_expect();
    act_v = {wbs, wme, mm, ALUop, stall_f, issue};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL model_cmp t=%0t instr=%h v=%b fl=%b: got %b expected %b",
               $time, instr, instr_valid, flush, act_v, exp_v);
    end
`ifdef HAZARD_COUNTERS_EN
    checks++;
    if (stall_cycles !== 16'(m_stall) || flush_count !== 16'(m_flush)) begin
      failures++;
      $display("FAIL counters t=%0t: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               $time, stall_cycles, flush_count, m_stall, m_flush);
    end
`endif
  end

  task automatic lit(input string name, input logic [6:0] exp_v);
    logic [6:0] act_v;
    act_v = {wbs, wme, mm, ALUop, stall_f, issue};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act_v, exp_v);
    end
  endtask

  task automatic cyc(input logic [31:0] i, input logic v, input logic f);
    @(posedge clk);
    #1;
    instr = i; instr_valid = v; flush = f;
    #1;
  endtask

  initial begin
    #2 lit("reset_outputs", 7'b0000000);
    #10 rst = 1'b0;

    cyc(mk(1, 1, 2, 3), 1'b1, 1'b0); lit("add_issue", 7'b1000001);
    cyc(mk(6, 0, 8, 9), 1'b1, 1'b0); lit("str_issue", 7'b0100001);

    // Load-use on rs1: one bubble, then issue.
    cyc(mk(5, 4, 2, 0), 1'b1, 1'b0); lit("ldr_issue", 7'b1010001);
    cyc(mk(1, 5, 4, 6), 1'b1, 1'b0); lit("ldu_bubble", 7'b0000010);
    cyc(mk(1, 5, 4, 6), 1'b1, 1'b0); lit("ldu_release", 7'b1000001);
    cyc(mk(5, 4, 2, 0), 1'b1, 1'b0); lit("ldr_again", 7'b1010001);
    cyc(mk(1, 5, 7, 6), 1'b1, 1'b0); lit("ld_no_dep", 7'b1000001);

    // Load-use via rs2, and LDR whose rs2 field matches but is not read.
    cyc(mk(5, 3, 1, 0), 1'b1, 1'b0); lit("ldr_r3", 7'b1010001);
    cyc(mk(2, 7, 1, 3), 1'b1, 1'b0); lit("ldu_rs2_bubble", 7'b0000010);
    cyc(mk(2, 7, 1, 3), 1'b1, 1'b0); lit("ldu_rs2_release", 7'b1000101);
    cyc(mk(5, 3, 1, 0), 1'b1, 1'b0); lit("ldr_r3_b", 7'b1010001);
    cyc(mk(5, 7, 1, 3), 1'b1, 1'b0); lit("ldr_rs2_ignored", 7'b1010001);

    // MUL occupancy: two stall cycles, then SUB.
    cyc(mk(3, 1, 2, 3), 1'b1, 1'b0); lit("mul_issue", 7'b1001001);
    cyc(mk(2, 2, 3, 4), 1'b1, 1'b0); lit("mul_busy1", 7'b0000010);
    cyc(mk(2, 2, 3, 4), 1'b1, 1'b0); lit("mul_busy2", 7'b0000010);
    cyc(mk(2, 2, 3, 4), 1'b1, 1'b0); lit("sub_after_mul", 7'b1000101);

    // Flush in first MUL_BUSY cycle abandons the stall.
    cyc(mk(3, 1, 2, 3), 1'b1, 1'b0); lit("mul_issue2", 7'b1001001);
    cyc(mk(1, 6, 7, 8), 1'b1, 1'b1); lit("flush_mul", 7'b0000000);
    cyc(mk(1, 6, 7, 8), 1'b1, 1'b0); lit("after_flush", 7'b1000001);

    // Flush with a load-use hazard clears the pending load.
    cyc(mk(5, 9, 1, 0), 1'b1, 1'b0); lit("ldr_r9", 7'b1010001);
    cyc(mk(4, 10, 1, 9), 1'b1, 1'b1); lit("flush_hazard", 7'b0000000);
    cyc(mk(4, 10, 1, 9), 1'b1, 1'b0); lit("and_no_stall", 7'b1001101);

    // NOP / undefined opcode / invalid slot.
    cyc(mk(0, 1, 2, 3), 1'b1, 1'b0); lit("nop_valid", 7'b0000001);
    cyc(mk(9, 1, 2, 3), 1'b1, 1'b0); lit("undef_op", 7'b0000001);
    cyc(mk(1, 1, 2, 3), 1'b0, 1'b0); lit("invalid_slot", 7'b0000000);

    // Async reset while in LD_STALL.
    cyc(mk(5, 4, 0, 0), 1'b1, 1'b0); lit("ldr_r4_c", 7'b1010001);
    cyc(mk(1, 5, 4, 6), 1'b1, 1'b0); lit("ldu_bubble_c", 7'b0000010);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 lit("async_rst", 7'b0000000);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 lit("held_after_rst", 7'b1000001);

    // Short pseudo-random tail checked only by the model.
    for (int k = 0; k < 60; k++) begin
      cyc(mk(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
          1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 11) == 0));
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_control_unit.md
Name: decode_control_unit

Overview:
- Decode-stage control generator. Drives the wbs/wme/mm/ALUop inputs of the DecodeExecute pipeline register.
- Adds the sequential hazard logic the pipeline needs:
  - load-use bubble insertion
  - multi-cycle MUL occupancy
  - flush from execute
- Also produces the fetch/IF-ID freeze signal.

Parameters:
- MUL_LAT, 3, execute cycles occupied by MUL (legal range 1..15).
- REG_AW, 4, register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- instr  input  32  IF/ID instruction: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm.
- instr_valid  input  1  IF/ID holds a real instruction.
- flush  input  1  branch/exception squash from execute.
- wbs  output  1  register-file write enable.
- wme  output  1  data-memory write enable.
- mm  output  1  writeback mux selects memory data.
- ALUop  output  2  00 add, 01 sub, 10 mul, 11 and.
- stall_f  output  1  hold PC and IF/ID this cycle.
- issue  output  1  current instruction is passed to DecodeExecute this cycle.

Behaviour:
- Opcode decode (wbs, wme, mm, ALUop):
  - 0 NOP: 0, 0, 0, 00
  - 1 ADD: 1, 0, 0, 00
  - 2 SUB: 1, 0, 0, 01
  - 3 MUL: 1, 0, 0, 10
  - 4 AND: 1, 0, 0, 11
  - 5 LDR: 1, 0, 1, 00
  - 6 STR: 0, 1, 0, 00
  - 7..15: treated as NOP.
- Outputs are combinational from state + instr. They appear in DecodeExecute one clk later (latency 1 to execute).
- Bubble: wbs, wme, mm = 0, ALUop = 00, issue = 0.
- Reset:
  - While rst is high: state = RUN, cnt = 0, ld_pend = 0, ld_rd = 0.
  - All outputs are forced to 0 asynchronously, independent of clk.
- FSM states RUN, LD_STALL, MUL_BUSY:
  - RUN, no hazard: issue = instr_valid. Decoded outputs are driven when instr_valid = 1, otherwise a bubble.
  - RUN, load-use hazard: hazard when instr_valid, ld_pend = 1, and ld_rd equals rs1, or equals rs2 for opcodes 1-4/6. Drive a bubble with stall_f = 1, then go to LD_STALL.
  - LD_STALL: clear ld_pend and issue the held instruction normally, then go to RUN. Exactly one bubble per load-use.
  - RUN issuing MUL with MUL_LAT > 1: load cnt = MUL_LAT-1, then go to MUL_BUSY.
  - MUL_BUSY: drive a bubble with stall_f = 1 and decrement cnt. When cnt reaches 1, go to RUN on the next edge. Total stall = MUL_LAT-1 cycles.
  - MUL_LAT = 1: MUL never enters MUL_BUSY.
- Load tracking:
  - On issue of LDR: ld_pend <= 1, ld_rd <= rd.
  - On any other issue, or on a bubble cycle from RUN without hazard: ld_pend <= 0.
- flush (highest priority):
  - Outputs are a bubble and stall_f = 0 in the flush cycle.
  - Next state RUN, cnt = 0, ld_pend = 0.
  - flush together with a hazard or during MUL_BUSY: flush wins and the stall is abandoned.
- instr_valid = 0 in RUN: bubble, stall_f = 0, no state change except ld_pend clear.
- Reset mid-stall: returns to RUN immediately. No issue is generated until rst deasserts.

Optional Feature:
- Macro HAZARD_COUNTERS_EN.
- Defined:
  - Adds output stall_cycles[15:0], incremented each cycle stall_f = 1.
  - Adds output flush_count[15:0], incremented each flush cycle.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: these ports and their logic do not exist. Functional behaviour is identical either way.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode_e enum (NOP..STR)
  - alu_op_t (2-bit) with ALU_ADD/SUB/MUL/AND constants
  - ctrl_t struct {wbs, wme, mm, ALUop}
  - state_e enum {RUN, LD_STALL, MUL_BUSY}
  - CTRL_BUBBLE constant
- Sub-module opcode_decoder: pure combinational opcode -> ctrl_t plus reads_rs2 flag. decode_control_unit instantiates it and owns the FSM, counter and load tracking.

Test Plan:
- Reset and basic decode: pulse rst with clk idle, check all outputs 0. Then ADD r1,r2,r3 valid -> wbs=1, wme=0, mm=0, ALUop=01? No: ALUop=00, issue=1, stall_f=0. Then STR -> wbs=0, wme=1, mm=0, ALUop=00.
- Load-use: LDR r4, then ADD r5,r4,r6 -> one cycle bubble with stall_f=1, next cycle ADD issued with ALUop=00. LDR r4 then ADD r5,r7,r6 -> no stall.
- MUL with MUL_LAT=3: MUL r1,r2,r3 issues (ALUop=10), then 2 cycles stall_f=1 with bubble, then the following SUB issues with ALUop=01.
- Flush priority: assert flush in the first MUL_BUSY cycle -> bubble, stall_f=0, next cycle back in RUN and the new instruction issues. Flush together with a load-use hazard -> no stall, ld_pend cleared.
- Async reset mid-LD_STALL: raise rst between edges -> outputs 0 immediately. After release, the held instruction issues without a bubble.
- HAZARD_COUNTERS_EN: run the load-use scenario plus the MUL scenario -> stall_cycles=3. After one flush -> flush_count=1. Force 65536 stall cycles -> stall_cycles holds at FFFF.
